// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller: FSM states, access lengths,
// and the length-normalisation helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIfRead,
    StMemRead,
    StMemWrite
  } state_e;

  localparam logic [2:0]  LenByte  = 3'd1;
  localparam logic [2:0]  LenHalf  = 3'd2;
  localparam logic [2:0]  LenWord  = 3'd4;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Anything other than a byte or halfword is serviced as a full word.
  function automatic logic [2:0] eff_len(input logic [2:0] len);
    logic [2:0] res;
    case (len)
      LenByte: res = LenByte;
      LenHalf: res = LenHalf;
      default: res = LenWord;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_byte_assembler.sv
// Byte counter plus little-endian merge buffer shared by instruction fetches and loads.
// word_o already includes the byte being captured this cycle.
module mem_byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        advance_i,
  input  logic        capture_i,
  input  logic [7:0]  byte_i,
  output logic [2:0]  cnt_o,
  output logic [31:0] word_o
);

  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  pos;

  always_comb begin
    // RAM data lags its address by one cycle, so the byte arriving now belongs to cnt-1.
    pos    = cnt_q[1:0] - 2'd1;
    word_o = word_q;
    if (capture_i) begin
      word_o[{pos, 3'b000} +: 8] = byte_i;
    end
    cnt_d  = cnt_q;
    word_d = word_q;
    if (start_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else begin
      if (advance_i) begin
        cnt_d = cnt_q + 3'd1;
      end
      word_d = word_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates IF fetches and MEM loads/stores onto a single byte-wide RAM port,
// serialising each access little-endian and pulsing a finished flag with the assembled data.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h30000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_enable_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_finished_o,
  output logic [31:0]           if_inst_o,
  output logic                  if_busy_o,
  input  logic                  mem_enable_i,
  input  logic                  mem_wr_i,
  input  logic [2:0]            mem_len_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [31:0]           mem_data_i,
  output logic                  mem_finished_o,
  output logic [31:0]           mem_data_o,
  output logic                  mem_busy_o,
  input  logic [7:0]            ram_din_i,
  output logic [7:0]            ram_dout_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_wr_o,
  input  logic                  io_buffer_full_i
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            len_q, len_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           inst_q, inst_d;
  logic [31:0]           mdata_q, mdata_d;
  logic                  fin_if_q, fin_if_d;
  logic                  fin_mem_q, fin_mem_d;
  logic                  if_busy_q, if_busy_d;
  logic                  mem_busy_q, mem_busy_d;

  logic                  asm_start, asm_adv, asm_cap;
  logic [2:0]            cnt;
  logic [31:0]           merged;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           wshift;
  logic                  io_hold;
  logic                  wr_c;

  mem_byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .start_i   (asm_start & rdy),
    .advance_i (asm_adv & rdy),
    .capture_i (asm_cap & rdy),
    .byte_i    (ram_din_i),
    .cnt_o     (cnt),
    .word_o    (merged)
  );

  assign cur_addr = addr_q + ADDR_WIDTH'(cnt);
  assign wshift   = wdata_q >> {cnt[1:0], 3'b000};
  assign io_hold  = (cur_addr[17:16] == IO_BASE[17:16]) && io_buffer_full_i;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    inst_d     = inst_q;
    mdata_d    = mdata_q;
    fin_if_d   = 1'b0;
    fin_mem_d  = 1'b0;
    if_busy_d  = if_busy_q;
    mem_busy_d = mem_busy_q;
    asm_start  = 1'b0;
    asm_adv    = 1'b0;
    asm_cap    = 1'b0;
    wr_c       = 1'b0;
    ram_addr_o = '0;
    ram_dout_o = 8'h00;

    unique case (state_q)
      StIdle: begin
        if_busy_d  = 1'b0;
        mem_busy_d = 1'b0;
        // The finished cycle still sees the requester's enable; skip it.
        if (!fin_if_q && !fin_mem_q) begin
          if (mem_enable_i) begin
            state_d    = mem_wr_i ? StMemWrite : StMemRead;
            addr_d     = mem_addr_i;
            len_d      = eff_len(mem_len_i);
            wdata_d    = mem_data_i;
            mem_busy_d = 1'b1;
            asm_start  = 1'b1;
          end else if (if_enable_i) begin
            state_d   = StIfRead;
            addr_d    = if_addr_i;
            len_d     = LenWord;
            if_busy_d = 1'b1;
            asm_start = 1'b1;
          end
        end
      end

      StIfRead: begin
        if (!if_enable_i) begin
          state_d   = StIdle;
          if_busy_d = 1'b0;
        end else begin
          asm_adv = 1'b1;
          asm_cap = (cnt != 3'd0);
          if (cnt < len_q) begin
            ram_addr_o = cur_addr;
          end
          if (cnt == len_q) begin
            state_d  = StIdle;
            fin_if_d = 1'b1;
            inst_d   = merged;
          end
        end
      end

      StMemRead: begin
        asm_adv = 1'b1;
        asm_cap = (cnt != 3'd0);
        if (cnt < len_q) begin
          ram_addr_o = cur_addr;
        end
        if (cnt == len_q) begin
          state_d   = StIdle;
          fin_mem_d = 1'b1;
          mdata_d   = merged;
        end
      end

      StMemWrite: begin
        ram_addr_o = cur_addr;
        ram_dout_o = wshift[7:0];
        if (!io_hold) begin
          wr_c    = 1'b1;
          asm_adv = 1'b1;
          if (cnt == len_q - 3'd1) begin
            state_d   = StIdle;
            fin_mem_d = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    ram_wr_o = wr_c & rdy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      wdata_q    <= ZeroWord;
      inst_q     <= ZeroWord;
      mdata_q    <= ZeroWord;
      fin_if_q   <= 1'b0;
      fin_mem_q  <= 1'b0;
      if_busy_q  <= 1'b0;
      mem_busy_q <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      inst_q     <= inst_d;
      mdata_q    <= mdata_d;
      fin_if_q   <= fin_if_d;
      fin_mem_q  <= fin_mem_d;
      if_busy_q  <= if_busy_d;
      mem_busy_q <= mem_busy_d;
    end
  end

  assign if_finished_o  = fin_if_q & rdy;
  assign mem_finished_o = fin_mem_q & rdy;
  assign if_inst_o      = inst_q;
  assign mem_data_o     = mdata_q;
  assign if_busy_o      = if_busy_q;
  assign mem_busy_o     = mem_busy_q;

endmodule
